// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port bundle shared by fetch and the BRAM model.
// The master drives the request; the slave returns data one cycle later.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 19
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage: PC, BRAM fetch, one-entry skid buffer and IF/ID register.
// Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 19,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                ifid_valid,
  output logic [31:0]         ifid_pc,
  output logic [31:0]         ifid_instr,
  output logic                fetch_misaligned
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  logic [31:0] fetch_pc;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  if_id_t      ifid;
  logic        halted;
  logic        misaligned_q;
  logic [31:0] target_pc;
  logic        req;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        tgt_bad;
  assign tgt_bad   = |redirect_pc[1:0];
  assign target_pc = redirect_pc;
`else
  logic        unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];
  assign target_pc  = {redirect_pc[31:2], 2'b00};
`endif

  assign req = rst_n & ~stall & ~redirect_valid & ~halted;

  assign imem.imem_en   = req;
  assign imem.imem_addr = fetch_pc[IMEM_ADDR_W+1:2];

  assign ifid_valid       = ifid.valid;
  assign ifid_pc          = ifid.pc;
  assign ifid_instr       = ifid.instr;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      resp_valid <= 1'b0;
      resp_pc    <= 32'h0;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= NOP_INSTR;
      ifid       <= '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};
    end else if (redirect_valid) begin
      fetch_pc    <= target_pc;
      resp_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      ifid.valid  <= 1'b0;
      ifid.instr  <= NOP_INSTR;
    end else begin
      if (req) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      resp_valid <= req;
      resp_pc    <= fetch_pc;
      if (stall) begin
        // fetch is gated while stalled, so only one word can land here
        if (resp_valid) begin
          skid_valid <= 1'b1;
          skid_pc    <= resp_pc;
          skid_instr <= imem.imem_rdata;
        end
      end else if (skid_valid) begin
        ifid       <= '{valid: 1'b1, pc: skid_pc, instr: skid_instr};
        skid_valid <= 1'b0;
      end else if (resp_valid) begin
        ifid <= '{valid: 1'b1, pc: resp_pc, instr: imem.imem_rdata};
      end else begin
        ifid.valid <= 1'b0;
        ifid.instr <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted       <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      halted       <= tgt_bad;
      misaligned_q <= tgt_bad;
    end
  end
`else
  assign halted       = 1'b0;
  assign misaligned_q = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the RV32I 5-stage pipeline. It owns the PC, issues word reads to the synchronous instruction-memory port (dual-port BRAM, 1-cycle read latency), and loads the IF/ID pipeline register with {pc, instruction, valid}. It absorbs BRAM latency under decode stalls with a one-entry skid buffer and accepts branch/jump redirects resolved in MEM.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset
- IMEM_ADDR_W, 19, word-address width of instruction memory (2 MB sim map)
- NOP_INSTR, 32'h00000013, value held in ifid_instr when no valid instruction (ADDI x0,x0,0)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_en  out  1  read enable to BRAM port A
- imem_addr  out  IMEM_ADDR_W  word address, = fetch_pc[IMEM_ADDR_W+1:2]
- imem_rdata  in  32  read data, valid the cycle after an enabled request
- stall  in  1  ID cannot accept; IF/ID must hold
- redirect_valid  in  1  taken branch / jump from MEM, flush younger instructions
- redirect_pc  in  32  redirect target
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pc  out  32  PC of ifid_instr
- ifid_instr  out  32  fetched instruction
- fetch_misaligned  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- State: fetch_pc, resp_valid + resp_pc (request in flight, data on imem_rdata this cycle), skid_valid/skid_pc/skid_instr, IF/ID register, halted.
- imem_en = rst_n & ~stall & ~redirect_valid & ~halted; fetch_pc advances by 4 (mod 2^32) only on an edge with imem_en=1; resp_valid <= imem_en, resp_pc <= fetch_pc.
- imem_addr drops fetch_pc[1:0] and bits above IMEM_ADDR_W+1 (address wraps in memory).
- IF/ID load (stall=0, no redirect): source priority skid > response; if neither, ifid_valid <= 0 and ifid_instr <= NOP_INSTR.
- stall=1: IF/ID holds; a response arriving that cycle is written to skid (skid_valid<=1). Skid never overflows: imem_en=0 while stalled, so at most one response lands after stall rises.
- Unstall with skid_valid: IF/ID <= skid, skid_valid <= 0; request issued same cycle arrives next cycle; no bubble.
- redirect_valid=1 (priority over stall): fetch_pc <= redirect_pc; resp_valid, skid_valid, ifid_valid <= 0; ifid_instr <= NOP_INSTR; in-flight data discarded.

## Timing
- Reset values: fetch_pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, resp_valid=0, skid_valid=0, fetch_misaligned=0, halted=0; imem_en=0 while rst_n low.
- Request at cycle t -> data on imem_rdata at t+1 -> ifid_valid at t+2. First instruction (RESET_PC) in IF/ID 2 cycles after rst_n release.
- Steady state: one instruction per cycle.
- Redirect in cycle t: target requested t+1, in IF/ID at t+3 (2 bubbles visible to ID).
- Reset asserted mid-stream: all state cleared immediately (async); in-flight BRAM data ignored.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 and halted=1; no further requests, ifid_valid stays 0. Cleared by reset or a later aligned redirect (which resumes fetch normally).
- Undefined: redirect_pc[1:0] forced to 0; fetch_misaligned tied 0; halted never set.

## Test plan
- Reset release, memory words 0x00000013,0x00100093,0x00200113 at 0x0/0x4/0x8 -> ifid_valid rises 2 cycles after release; ifid_pc 0x0,0x4,0x8 on consecutive cycles with matching instructions.
- stall=1 for 3 cycles while stream flows -> IF/ID frozen, imem_en=0, skid captures one word; after release pcs continue with no gap and no duplicate.
- redirect_valid with redirect_pc=0x100 at cycle t -> ifid_valid=0 at t+1,t+2; ifid_pc=0x100 valid at t+3; in-flight words never appear.
- redirect and stall asserted together while skid_valid=1 -> skid dropped, ifid_valid=0 next cycle, stream restarts at target.
- fetch_pc at 0xFFFFFFFC -> next imem_addr corresponds to 0x0 (wrap), ifid_pc=0x00000000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> fetch_misaligned=1, imem_en=0 thereafter; redirect_pc=0x200 -> flag clears, 0x200 in IF/ID 3 cycles later. Without macro: 0x102 fetches 0x100.
